// File: rtl/fetch_queue_pkg.sv
// Shared defaults and helpers for the dual-issue fetch queue.
// Optional build macro used by this slice: FETCH_QUEUE_BYPASS_EN.
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 8;
  localparam int PC_BUS   = 32;
  localparam int INST_BUS = 32;

  // issue[1] qualifies slot 1 (older), issue[0] qualifies slot 2 (younger).
  typedef enum logic [1:0] {
    ISSUE_NONE  = 2'b00,
    ISSUE_SLOT2 = 2'b01,
    ISSUE_SLOT1 = 2'b10,
    ISSUE_BOTH  = 2'b11
  } issue_e;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/fetch_queue_ptr.sv
// Head/tail/count bookkeeping for fetch_queue: enqueue/dequeue clipping and stop.
// With FETCH_QUEUE_BYPASS_EN, an empty queue lets ID consume same-cycle fetches.
module fetch_queue_ptr
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       issue,
  input  logic [1:0]       deq,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             stop,
  output logic             enq
);

  logic [1:0]       nenq;
  logic [1:0]       ndeq;
  logic [1:0]       deq_c;
  logic [CNT_W-1:0] avail;

  always_comb begin
    // stop looks only at the registered count, so IF never sees a path from issue/deq.
    stop  = count > CNT_W'(DEPTH - 2);
    enq   = !stop && !flush;
    nenq  = enq ? popcount2(issue) : 2'd0;
    deq_c = (deq == 2'b11) ? 2'd2 : deq;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Bypassed entries are written at tail and retired at once by advancing head past them.
    avail = (count == '0) ? CNT_W'(nenq) : count;
`else
    avail = count;
`endif
    ndeq  = (CNT_W'(deq_c) > avail) ? avail[1:0] : deq_c;
  end

  // NOTE: state registers use non-blocking assignments and an async reset branch only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(ndeq);
      tail  <= tail + PTR_W'(nenq);
      count <= count + CNT_W'(nenq) - CNT_W'(ndeq);
    end
  end

  deq_legal: assert property (@(posedge clk) disable iff (rst)
    !flush |-> (deq != 2'b11 && CNT_W'(deq) <= avail))
    else $error("fetch_queue: deq=%0d exceeds available entries %0d", deq, avail);

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction queue between IF and ID: entry storage and output muxing.
// Define FETCH_QUEUE_BYPASS_EN to forward fetches to ID in the same cycle when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int PC_W   = PC_BUS,
  parameter int INST_W = INST_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [1:0]        issue,
  input  logic [PC_W-1:0]   in1_pc,
  input  logic [PC_W-1:0]   in1_npc,
  input  logic [INST_W-1:0] in1_inst,
  input  logic [PC_W-1:0]   in2_pc,
  input  logic [PC_W-1:0]   in2_npc,
  input  logic [INST_W-1:0] in2_inst,
  output logic              stop,
  output logic              out1_valid,
  output logic [PC_W-1:0]   out1_pc,
  output logic [PC_W-1:0]   out1_npc,
  output logic [INST_W-1:0] out1_inst,
  output logic              out2_valid,
  output logic [PC_W-1:0]   out2_pc,
  output logic [PC_W-1:0]   out2_npc,
  output logic [INST_W-1:0] out2_inst,
  input  logic [1:0]        deq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   npc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [PTR_W-1:0] head, tail, head_nx, tail_nx;
  logic [CNT_W-1:0] count;
  logic             enq;
  entry_t           mem [DEPTH];
  entry_t           slot0, slot1, d1, d2;
  logic             v1, v2;

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .issue (issue),
    .deq   (deq),
    .head  (head),
    .tail  (tail),
    .count (count),
    .stop  (stop),
    .enq   (enq)
  );

  assign head_nx = head + PTR_W'(1);
  assign tail_nx = tail + PTR_W'(1);

  // Compact the fetch pair so the oldest valid slot always lands at tail.
  assign slot0 = issue[1] ? entry_t'{in1_pc, in1_npc, in1_inst}
                          : entry_t'{in2_pc, in2_npc, in2_inst};
  assign slot1 = entry_t'{in2_pc, in2_npc, in2_inst};

  // NOTE: entry storage has no reset; the valid flags derived from count guard it.
  always_ff @(posedge clk) begin
    if (enq && issue != ISSUE_NONE) mem[tail]    <= slot0;
    if (enq && issue == ISSUE_BOTH) mem[tail_nx] <= slot1;
  end

  always_comb begin
    v1 = count != '0;
    v2 = count >= CNT_W'(2);
    d1 = mem[head];
    d2 = mem[head_nx];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (count == '0 && !flush) begin
      v1 = issue != ISSUE_NONE;
      v2 = issue == ISSUE_BOTH;
      d1 = slot0;
      d2 = slot1;
    end
`endif
    if (!v1) d1 = '0;
    if (!v2) d2 = '0;
  end

  assign out1_valid = v1;
  assign out1_pc    = d1.pc;
  assign out1_npc   = d1.npc;
  assign out1_inst  = d1.inst;
  assign out2_valid = v2;
  assign out2_pc    = d2.pc;
  assign out2_npc   = d2.npc;
  assign out2_inst  = d2.inst;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model (handles FETCH_QUEUE_BYPASS_EN).
module tb_fetch_queue;

  localparam int DEPTH = 8;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] inst;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  issue;
  logic [1:0]  deq;
  logic [31:0] in1_pc, in1_npc, in1_inst, in2_pc, in2_npc, in2_inst;
  logic        stop, out1_valid, out2_valid;
  logic [31:0] out1_pc, out1_npc, out1_inst, out2_pc, out2_npc, out2_inst;

  int total = 0;
  int bad   = 0;
  entry_t q[$];
  logic [31:0] next_pc;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .issue(issue),
    .in1_pc(in1_pc), .in1_npc(in1_npc), .in1_inst(in1_inst),
    .in2_pc(in2_pc), .in2_npc(in2_npc), .in2_inst(in2_inst),
    .stop(stop),
    .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_npc(out1_npc), .out1_inst(out1_inst),
    .out2_valid(out2_valid), .out2_pc(out2_pc), .out2_npc(out2_npc), .out2_inst(out2_inst),
    .deq(deq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] pc);
    return '{pc, pc + 32'd8, pc ^ 32'hC0DE_5A5A};
  endfunction

  function automatic int ones(input logic [1:0] v);
    return int'(v[1]) + int'(v[0]);
  endfunction

  // Entries ID may legally take this cycle, per the model.
  function automatic int legal_deq(input int want, input logic f, input logic [1:0] iss);
    int a;
    a = (BYP && q.size() == 0 && !f) ? ones(iss) : q.size();
    if (a > 2) a = 2;
    return (want < a) ? want : a;
  endfunction

  task automatic check_outputs(input string tag, input logic f, input logic [1:0] iss,
                               input entry_t e1, input entry_t e2);
    entry_t v[$];
    entry_t x1, x2;
    if (BYP && q.size() == 0 && !f) begin
      if (iss[1]) v.push_back(e1);
      if (iss[0]) v.push_back(e2);
    end else begin
      v = q;
    end
    x1 = (v.size() >= 1) ? v[0] : '0;
    x2 = (v.size() >= 2) ? v[1] : '0;
    chk({tag, ".stop"}, 32'(stop), 32'(DEPTH - q.size() < 2));
    chk({tag, ".v1"},   32'(out1_valid), 32'(v.size() >= 1));
    chk({tag, ".v2"},   32'(out2_valid), 32'(v.size() >= 2));
    chk({tag, ".pc1"},  out1_pc,   x1.pc);
    chk({tag, ".npc1"}, out1_npc,  x1.npc);
    chk({tag, ".ins1"}, out1_inst, x1.inst);
    chk({tag, ".pc2"},  out2_pc,   x2.pc);
    chk({tag, ".npc2"}, out2_npc,  x2.npc);
    chk({tag, ".ins2"}, out2_inst, x2.inst);
  endtask

  // One clock: drive at negedge, check before the edge, update the model after it.
  task automatic step(input string tag, input logic f, input logic [1:0] iss,
                      input int dq, input entry_t e1, input entry_t e2);
    int nd;
    bit full;
    flush = f; issue = iss; deq = 2'(dq);
    {in1_pc, in1_npc, in1_inst} = e1;
    {in2_pc, in2_npc, in2_inst} = e2;
    #1;
    check_outputs(tag, f, iss, e1, e2);
    nd   = legal_deq(dq, f, iss);
    full = (DEPTH - q.size() < 2);
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      if (!full && iss[1]) q.push_back(e1);
      if (!full && iss[0]) q.push_back(e2);
      repeat (nd) void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic pair(input string tag, input logic [1:0] iss, input int want_deq);
    entry_t e1, e2;
    e1 = mk(next_pc);
    e2 = mk(next_pc + 32'd4);
    step(tag, 1'b0, iss, legal_deq(want_deq, 1'b0, iss), e1, e2);
    if (DEPTH - q.size() >= 0 && !(DEPTH - q.size() < 2)) next_pc += 32'd8;
  endtask

  task automatic idle(input string tag, input int want_deq);
    step(tag, 1'b0, 2'b00, legal_deq(want_deq, 1'b0, 2'b00), '0, '0);
  endtask

  // Asynchronous reset applied between edges: outputs must clear at once.
  task automatic do_reset(input string tag);
    flush = 1'b0; issue = 2'b00; deq = 2'b00;
    #2 rst = 1'b1;
    #1;
    q.delete();
    check_outputs(tag, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue = 2'b00; deq = 2'b00;
    {in1_pc, in1_npc, in1_inst, in2_pc, in2_npc, in2_inst} = '0;
    next_pc = 32'h100;
    #1;
    check_outputs("reset", 1'b0, 2'b00, '0, '0);
    @(negedge clk);
    rst = 1'b0;

    // Pair into an empty queue, then seen by ID.
    step("t1.enq", 1'b0, 2'b11, 0, mk(32'h100), mk(32'h104));
    idle("t1.out", 0);

    // Younger slot only.
    do_reset("t2.rst");
    step("t2.enq", 1'b0, 2'b01, 0, mk(32'h200), mk(32'h204));
    idle("t2.out", 0);

    // Fill to the stop threshold; issue while stopped is ignored.
    do_reset("t3.rst");
    next_pc = 32'h1000;
    repeat (5) pair("t3.fill", 2'b11, 0);
    repeat (2) pair("t3.hold", 2'b11, 0);
    idle("t3.full", 0);
    idle("t3.drain", 2);

    // count=5 with simultaneous pair enqueue and double dequeue.
    do_reset("t4.rst");
    pair("t4.a", 2'b11, 0);
    pair("t4.b", 2'b11, 0);
    pair("t4.c", 2'b10, 0);
    pair("t4.mix", 2'b11, 2);
    idle("t4.out", 0);

    // Flush beats enqueue and dequeue.
    do_reset("t5.rst");
    pair("t5.a", 2'b11, 0);
    pair("t5.b", 2'b11, 0);
    step("t5.flush", 1'b1, 2'b11, 1, mk(32'hDEAD0), mk(32'hDEAD4));
    idle("t5.after", 0);

    // Move tail to 7, then stream pairs across the wrap point.
    do_reset("t6.rst");
    next_pc = 32'h4000;
    repeat (7) pair("t6.pre", 2'b10, 1);
    for (int i = 0; i < 8 && q.size() != 0; i++) idle("t6.drain", 2);
    next_pc = 32'h8000;
    repeat (20) pair("t6.stream", 2'b11, 2);
    for (int i = 0; i < 8 && q.size() != 0; i++) idle("t6.tail", 2);
    chk("t6.empty", 32'(q.size()), 32'd0);

    // Random traffic with occasional flush and one mid-run reset.
    for (int i = 0; i < 300; i++) begin
      logic f;
      logic [1:0] iss;
      entry_t e1, e2;
      if (i == 150) do_reset("rnd.rst");
      f   = ($urandom_range(0, 19) == 0);
      iss = 2'($urandom_range(0, 3));
      e1  = '{$urandom, $urandom, $urandom};
      e2  = '{$urandom, $urandom, $urandom};
      step("rnd", f, iss, legal_deq(int'($urandom_range(0, 2)), f, iss), e1, e2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
